// File: rtl/aes_io_ctrl.sv
// aes_io_ctrl: pin-side sequencer for the 128-bit AES core.
// Loads plaintext/key nibble-serially (or a built-in known-answer vector in
// test mode), strobes the core, waits for completion, then streams the
// ciphertext out one byte per cycle, MSB byte first.
// Optional build macro: AES_IO_CTRL_TIMEOUT_EN adds a WAIT watchdog with err pulse.
//
// state   | meaning
// IDLE    | waiting for en; test selects nibble load or built-in vector
// LOAD    | shifting the remaining plaintext/key nibbles
// START   | one-cycle core_ld strobe
// WAIT    | waiting for core_done (optionally bounded by the watchdog)
// DRAIN   | one ciphertext byte per cycle on result
// DONE    | one-cycle done pulse, back to IDLE
module aes_io_ctrl #(
  parameter int DATA_W  = 128,
  parameter int IN_W    = 4,
  parameter int OUT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              test,
  input  logic [IN_W-1:0]   block,
  input  logic [IN_W-1:0]   key,
  output logic [OUT_W-1:0]  result,
  output logic              result_vld,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] core_text_in,
  output logic [DATA_W-1:0] core_key_in,
  output logic              core_ld,
  input  logic [DATA_W-1:0] core_text_out,
  input  logic              core_done
);

  localparam int NIB   = DATA_W / IN_W;
  localparam int NBYTE = DATA_W / OUT_W;
  localparam int CNT_W = $clog2((NIB > NBYTE) ? NIB : NBYTE) + 1;

  localparam logic [127:0] KAT_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  if ((DATA_W % IN_W) != 0 || (DATA_W % OUT_W) != 0 || TIMEOUT < 1) begin : g_param_err
    $error("aes_io_ctrl: DATA_W must be a multiple of IN_W and OUT_W, TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] out_sr;

`ifdef AES_IO_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = test ? S_START : S_LOAD;
      S_LOAD:  if (cnt == CNT_W'(NIB - 2)) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) state_nxt = S_DRAIN;
`ifdef AES_IO_CTRL_TIMEOUT_EN
        else if (wd_expired) state_nxt = S_IDLE;
`endif
      end
      S_DRAIN: if (cnt == CNT_W'(NBYTE - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered Moore outputs, shift registers and the shared LOAD/DRAIN counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      core_ld      <= 1'b0;
      result_vld   <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      core_text_in <= '0;
      core_key_in  <= '0;
      out_sr       <= '0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      core_ld    <= (state_nxt == S_START);
      result_vld <= (state_nxt == S_DRAIN);
      done       <= (state_nxt == S_DONE);

      if (state_nxt != state)
        cnt <= '0;
      else if (state == S_LOAD || state == S_DRAIN)
        cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE && en && test) begin
        core_text_in <= DATA_W'(KAT_TEXT);
        core_key_in  <= DATA_W'(KAT_KEY);
      end else if ((state == S_IDLE && en) || state == S_LOAD) begin
        core_text_in <= {core_text_in[DATA_W-IN_W-1:0], block};
        core_key_in  <= {core_key_in[DATA_W-IN_W-1:0], key};
      end

      if (state == S_WAIT && core_done)
        out_sr <= core_text_out;
      else if (state == S_DRAIN)
        out_sr <= {out_sr[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
    end
  end

  // Top byte is only exposed while valid, so result idles at zero
  assign result = result_vld ? out_sr[DATA_W-1 -: OUT_W] : '0;

`ifdef AES_IO_CTRL_TIMEOUT_EN
  // Watchdog: counts WAIT cycles, clears outside WAIT, pulses err on expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err    <= (state == S_WAIT) && !core_done && wd_expired;
      wd_cnt <= (state == S_WAIT) ? wd_cnt + WD_W'(1) : '0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_io_ctrl.sv
// Directed testbench for aes_io_ctrl; the core is emulated by the tasks.
module tb_aes_io_ctrl;

  localparam int DATA_W = 128;
  localparam int IN_W   = 4;
  localparam int OUT_W  = 8;

  localparam logic [127:0] KAT_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst_n, en, test, result_vld, done, busy, err, core_ld, core_done;
  logic [IN_W-1:0]   block, key;
  logic [OUT_W-1:0]  result;
  logic [DATA_W-1:0] core_text_in, core_key_in, core_text_out;

  logic [7:0] kat_bytes [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                                 8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  int checks = 0;
  int errors = 0;

  aes_io_ctrl #(.DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .test(test), .block(block), .key(key),
    .result(result), .result_vld(result_vld), .done(done), .busy(busy), .err(err),
    .core_text_in(core_text_in), .core_key_in(core_key_in), .core_ld(core_ld),
    .core_text_out(core_text_out), .core_done(core_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [267:0] obs;
    rst_n = 1'b0; en = 1'b0; test = 1'b0; block = '0; key = '0;
    core_done = 1'b0; core_text_out = '0;
    tick(); tick();
    obs = {result, result_vld, done, busy, err, core_ld, core_text_in, core_key_in};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", obs); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = {result, result_vld, done, busy, err, core_ld, core_text_in, core_key_in};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_idle[%0d]: got %h expected 0", i, obs); end
    end
  endtask

  task automatic test_kat();
    test = 1'b1; en = 1'b1;
    tick();
    en = 1'b0; test = 1'b0;
    checks++;
    if ({core_ld, busy} !== 2'b11) begin errors++; $display("FAIL kat_ld: got ld=%b busy=%b expected 1 1", core_ld, busy); end
    checks++;
    if (core_text_in !== KAT_TEXT) begin errors++; $display("FAIL kat_text: got %h expected %h", core_text_in, KAT_TEXT); end
    checks++;
    if (core_key_in !== KAT_KEY) begin errors++; $display("FAIL kat_key: got %h expected %h", core_key_in, KAT_KEY); end
    tick();
    checks++;
    if ({core_ld, busy, result_vld} !== 3'b010) begin errors++; $display("FAIL kat_wait: got ld=%b busy=%b vld=%b expected 0 1 0", core_ld, busy, result_vld); end
    tick(); tick();
    core_text_out = KAT_CT; core_done = 1'b1;
    tick();
    core_done = 1'b0; core_text_out = '0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({result_vld, done, result} !== {1'b1, 1'b0, kat_bytes[i]}) begin
        errors++; $display("FAIL kat_byte[%0d]: got vld=%b done=%b byte=%h expected 1 0 %h", i, result_vld, done, result, kat_bytes[i]);
      end
      tick();
    end
    checks++;
    if ({done, result_vld, result, busy} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      errors++; $display("FAIL kat_done: got done=%b vld=%b byte=%h busy=%b expected 1 0 00 1", done, result_vld, result, busy);
    end
    tick();
    checks++;
    if ({done, busy, core_text_in} !== {2'b00, KAT_TEXT}) begin
      errors++; $display("FAIL kat_idle: got done=%b busy=%b text=%h expected 0 0 %h", done, busy, core_text_in, KAT_TEXT);
    end
  endtask

  task automatic test_nibble();
    logic [127:0] exp5, ct;
    exp5 = {32{4'h5}};
    ct   = 128'h0f0e0d0c0b0a09080706050403020100;
    block = 4'h5; key = 4'h5; en = 1'b1;
    tick();
    en = 1'b0;
    for (int c = 1; c < 32; c++) begin
      checks++;
      if ({busy, core_ld} !== 2'b10) begin errors++; $display("FAIL nib_load[%0d]: got busy=%b ld=%b expected 1 0", c, busy, core_ld); end
      tick();
    end
    checks++;
    if (core_ld !== 1'b1) begin errors++; $display("FAIL nib_ld32: got %b expected 1", core_ld); end
    checks++;
    if ({core_text_in, core_key_in} !== {exp5, exp5}) begin
      errors++; $display("FAIL nib_regs: got %h %h expected %h", core_text_in, core_key_in, exp5);
    end
    block = 4'h0; key = 4'h0;
    tick();
    checks++;
    if ({core_ld, core_text_in} !== {1'b0, exp5}) begin errors++; $display("FAIL nib_wait: got ld=%b text=%h expected 0 %h", core_ld, core_text_in, exp5); end
    core_done = 1'b1; core_text_out = ct;
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({result_vld, result} !== {1'b1, ct[127-8*i -: 8]}) begin
        errors++; $display("FAIL nib_byte[%0d]: got vld=%b byte=%h expected 1 %h", i, result_vld, result, ct[127-8*i -: 8]);
      end
      tick();
    end
    checks++;
    if ({done, result_vld} !== 2'b10) begin errors++; $display("FAIL nib_done: got done=%b vld=%b expected 1 0", done, result_vld); end
    core_done = 1'b0;
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL nib_idle: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_nibble_order();
    int ld_cnt, vld_cnt, done_cnt;
    logic [3:0] n;
    ld_cnt = 0; vld_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      n = c[3:0];
      block = n; key = ~n; en = 1'b1;
      tick();
      if (core_ld) ld_cnt++;
    end
    en = 1'b0;
    checks++;
    if ({ld_cnt, core_ld} !== {32'd1, 1'b1}) begin errors++; $display("FAIL ord_ld: got count=%0d ld=%b expected 1 1", ld_cnt, core_ld); end
    checks++;
    if (core_text_in !== 128'h0123456789abcdef0123456789abcdef) begin
      errors++; $display("FAIL ord_text: got %h expected 0123456789abcdef0123456789abcdef", core_text_in);
    end
    checks++;
    if (core_key_in !== 128'hfedcba9876543210fedcba9876543210) begin
      errors++; $display("FAIL ord_key: got %h expected fedcba9876543210fedcba9876543210", core_key_in);
    end
    tick();
    core_done = 1'b1; core_text_out = 128'hdeadbeef00112233445566778899aabb;
    tick();
    core_done = 1'b0;
    checks++;
    if (result !== 8'hde) begin errors++; $display("FAIL ord_first: got %h expected de", result); end
    for (int k = 0; k < 20; k++) begin
      if (result_vld) vld_cnt++;
      if (done) done_cnt++;
      tick();
    end
    checks++;
    if ({vld_cnt, done_cnt, busy} !== {32'd16, 32'd1, 1'b0}) begin
      errors++; $display("FAIL ord_drain: got vld=%0d done=%0d busy=%b expected 16 1 0", vld_cnt, done_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int ld_cnt, done_cyc;
    ld_cnt = 0; done_cyc = -1;
    test = 1'b1; en = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      if (cyc == 3) begin core_text_out = KAT_CT; core_done = 1'b1; end
      if (cyc == 4) core_done = 1'b0;
      if (cyc <= 20 && core_ld) ld_cnt++;
      if (done) done_cyc = cyc;
      if (cyc == 21) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
      end
      if (cyc == 22) begin
        checks++;
        if (core_ld !== 1'b1) begin errors++; $display("FAIL b2b_second_ld: got %b expected 1", core_ld); end
      end
    end
    checks++;
    if ({ld_cnt, done_cyc} !== {32'd1, 32'd20}) begin
      errors++; $display("FAIL b2b_first_job: got ld=%0d done_cycle=%0d expected 1 20", ld_cnt, done_cyc);
    end
    en = 1'b0; test = 1'b0;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    checks++;
    if ({busy, done, core_ld} !== 3'b000) begin errors++; $display("FAIL b2b_end: got busy=%b done=%b ld=%b expected 0 0 0", busy, done, core_ld); end
  endtask

  task automatic test_reset_mid();
    block = 4'ha; key = 4'h3; en = 1'b1; test = 1'b0;
    tick();
    en = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, core_ld, result_vld, done, result, core_text_in, core_key_in} !== '0) begin
      errors++; $display("FAIL rst_mid_async: got busy=%b text=%h key=%h expected all 0", busy, core_text_in, core_key_in);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0", busy); end
    test = 1'b1; en = 1'b1;
    tick();
    en = 1'b0; test = 1'b0;
    checks++;
    if ({core_ld, core_text_in} !== {1'b1, KAT_TEXT}) begin errors++; $display("FAIL rst_mid_kat_ld: got ld=%b text=%h", core_ld, core_text_in); end
    tick();
    core_done = 1'b1; core_text_out = KAT_CT;
    tick();
    core_done = 1'b0;
    checks++;
    if (result !== 8'h69) begin errors++; $display("FAIL rst_mid_first: got %h expected 69", result); end
    for (int k = 0; k < 16; k++) tick();
    checks++;
    if ({done, result_vld} !== 2'b10) begin errors++; $display("FAIL rst_mid_done: got done=%b vld=%b expected 1 0", done, result_vld); end
    tick();
  endtask

  task automatic test_timeout();
    core_done = 1'b0;
    test = 1'b1; en = 1'b1;
    tick();
    en = 1'b0; test = 1'b0;
    tick();
`ifdef AES_IO_CTRL_TIMEOUT_EN
    for (int c = 2; c < 66; c++) begin
      checks++;
      if ({err, busy, done} !== 3'b010) begin errors++; $display("FAIL to_wait[%0d]: got err=%b busy=%b done=%b expected 0 1 0", c, err, busy, done); end
      tick();
    end
    checks++;
    if ({err, busy, done, core_text_in} !== {3'b100, KAT_TEXT}) begin
      errors++; $display("FAIL to_err: got err=%b busy=%b done=%b text=%h expected 1 0 0 %h", err, busy, done, core_text_in, KAT_TEXT);
    end
    tick();
    checks++;
    if ({err, busy, done} !== 3'b000) begin errors++; $display("FAIL to_after: got err=%b busy=%b done=%b expected 0 0 0", err, busy, done); end
`else
    for (int c = 0; c < 1000; c++) begin
      checks++;
      if ({err, busy, done} !== 3'b010) begin errors++; $display("FAIL to_hang[%0d]: got err=%b busy=%b done=%b expected 0 1 0", c, err, busy, done); end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_recover: got busy=%b expected 0", busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_kat();
    test_nibble();
    test_nibble_order();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
